// File: rtl/audio_i2s_clkgen_pkg.sv
// audio_i2s_clkgen_pkg: frame geometry and handshake states shared by the I2S clock generator and serializer.
package audio_i2s_clkgen_pkg;
    localparam int BCLK_PER_FRAME = 64;
    localparam int BCLK_PER_CH    = 32;
    localparam int UPDATE_BCLK    = 16;
    localparam int BCLK_CNT_W     = $clog2(BCLK_PER_FRAME);
    typedef enum logic {WAIT_DATA, HAVE_DATA} state_t;
endpackage

// File: rtl/audio_bclk_divider.sv
// audio_bclk_divider: divides the master clock into registered BCLK/LRCK and flags the mid-left-half update point.
module audio_bclk_divider
    import audio_i2s_clkgen_pkg::*;
#(
    parameter int MCLK_PER_BCLK = 4
) (
    input  logic iAUD_XCK,
    input  logic reset_reg_N,
    output logic oAUD_BCLK,
    output logic oAUD_DACLRCK,
    output logic o_update
);
    localparam int DW = $clog2(MCLK_PER_BCLK);
    localparam logic [DW-1:0] DIV_MAX  = DW'(MCLK_PER_BCLK - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_PER_BCLK / 2 - 1);

    logic [DW-1:0]         r_div_cnt;
    logic [BCLK_CNT_W-1:0] r_bclk_cnt;
    logic [BCLK_CNT_W-1:0] w_bclk_next;
    logic                  w_tick;

    assign w_tick      = r_div_cnt == DIV_MAX;
    assign w_bclk_next = r_bclk_cnt + 1'b1;
    assign o_update    = w_tick && r_bclk_cnt == BCLK_CNT_W'(UPDATE_BCLK - 1);

    always_ff @(posedge iAUD_XCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_div_cnt    <= '0;
            r_bclk_cnt   <= '0;
            oAUD_BCLK    <= 1'b0;
            oAUD_DACLRCK <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_bclk_cnt   <= w_bclk_next;
                oAUD_BCLK    <= 1'b0;
                // LRCK moves with the BCLK falling edge; the MSB selects the channel half
                oAUD_DACLRCK <= w_bclk_next[BCLK_CNT_W-1];
            end else if (r_div_cnt == DIV_HALF) begin
                oAUD_BCLK <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/audio_i2s_clkgen.sv
// audio_i2s_clkgen: I2S timing master; requests one stereo sample per frame and presents frame-stable words.
module audio_i2s_clkgen
    import audio_i2s_clkgen_pkg::*;
#(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int MCLK_PER_BCLK = 4
) (
    input  logic                     iAUD_XCK,
    input  logic                     reset_reg_N,
    input  logic [AUD_BIT_DEPTH-1:0] i_lsound,
    input  logic [AUD_BIT_DEPTH-1:0] i_rsound,
    input  logic                     i_sample_valid,
    output logic                     oAUD_BCLK,
    output logic                     oAUD_DACLRCK,
    output logic [AUD_BIT_DEPTH-1:0] o_lsound_out,
    output logic [AUD_BIT_DEPTH-1:0] o_rsound_out,
    output logic                     o_sample_req,
    output logic                     o_underrun,
    output logic                     o_underrun_sticky
);
    if (MCLK_PER_BCLK < 2 || MCLK_PER_BCLK % 2 != 0) begin : g_bad_div
        $error("MCLK_PER_BCLK must be even and at least 2");
    end

    logic                     w_update;
    state_t                   r_state;
    logic [AUD_BIT_DEPTH-1:0] r_lstage;
    logic [AUD_BIT_DEPTH-1:0] r_rstage;

    audio_bclk_divider #(.MCLK_PER_BCLK(MCLK_PER_BCLK)) u_div (
        .iAUD_XCK    (iAUD_XCK),
        .reset_reg_N (reset_reg_N),
        .oAUD_BCLK   (oAUD_BCLK),
        .oAUD_DACLRCK(oAUD_DACLRCK),
        .o_update    (w_update)
    );

    // Reset into HAVE_DATA so the first update presents the zeroed staging without an underrun
    always_ff @(posedge iAUD_XCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_state           <= HAVE_DATA;
            r_lstage          <= '0;
            r_rstage          <= '0;
            o_lsound_out      <= '0;
            o_rsound_out      <= '0;
            o_sample_req      <= 1'b0;
            o_underrun        <= 1'b0;
            o_underrun_sticky <= 1'b0;
        end else begin
            o_sample_req <= w_update;
            o_underrun   <= 1'b0;
            case (r_state)
                WAIT_DATA: begin
                    if (w_update && i_sample_valid) begin
                        o_lsound_out <= i_lsound;
                        o_rsound_out <= i_rsound;
                    end else if (w_update) begin
                        o_underrun        <= 1'b1;
                        o_underrun_sticky <= 1'b1;
                    end else if (i_sample_valid) begin
                        r_lstage <= i_lsound;
                        r_rstage <= i_rsound;
                        r_state  <= HAVE_DATA;
                    end
                end
                HAVE_DATA: begin
                    if (w_update) begin
                        o_lsound_out <= r_lstage;
                        o_rsound_out <= r_rstage;
                        r_state      <= WAIT_DATA;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_i2s_clkgen.sv
// tb_audio_i2s_clkgen: directed frame table plus randomized traffic checked against a frame-window reference model.
module tb_audio_i2s_clkgen;
    localparam int D = 24;
    localparam int M = 4;
    localparam int FRAME = 64 * M;
    localparam int UPD = 16 * M;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [D-1:0] i_l = '0, i_r = '0;
    logic i_v = 1'b0;
    logic bclk, lrck, req, und, sticky;
    logic [D-1:0] o_l, o_r;

    int n_cmp = 0;
    int n_fail = 0;

    audio_i2s_clkgen #(.AUD_BIT_DEPTH(D), .MCLK_PER_BCLK(M)) dut (
        .iAUD_XCK         (clk),
        .reset_reg_N      (rst_n),
        .i_lsound         (i_l),
        .i_rsound         (i_r),
        .i_sample_valid   (i_v),
        .oAUD_BCLK        (bclk),
        .oAUD_DACLRCK     (lrck),
        .o_lsound_out     (o_l),
        .o_rsound_out     (o_r),
        .o_sample_req     (req),
        .o_underrun       (und),
        .o_underrun_sticky(sticky)
    );

    always #5 clk = ~clk;

    // Reference: time since reset gives the clocks; each update publishes the first sample of its window
    int m_t;
    logic m_bclk, m_lrck, m_req, m_und, m_sticky, m_first, m_have;
    logic [D-1:0] m_l, m_r, w_l, w_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_bclk = 0; m_lrck = 0; m_req = 0; m_und = 0; m_sticky = 0;
            m_first = 1; m_have = 0; m_l = '0; m_r = '0; w_l = '0; w_r = '0;
        end else begin
            m_t = m_t + 1;
            m_req = 0;
            m_und = 0;
            if (i_v && !m_have) begin
                m_have = 1; w_l = i_l; w_r = i_r;
            end
            if (m_t % FRAME == UPD) begin
                m_req = 1;
                if (m_first) m_first = 0;
                else if (m_have) begin
                    m_l = w_l; m_r = w_r;
                end else begin
                    m_und = 1; m_sticky = 1;
                end
                m_have = 0;
            end
            m_bclk = (m_t % M) >= M / 2;
            m_lrck = ((m_t / M) % 64) >= 32;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic step(input logic v, input logic [D-1:0] l, input logic [D-1:0] r);
        i_v = v; i_l = l; i_r = r;
        @(negedge clk);
        chk("model", {bclk, lrck, o_l, o_r, req, und, sticky},
                     {m_bclk, m_lrck, m_l, m_r, m_req, m_und, m_sticky});
    endtask

    task automatic wait_req(input string name);
        bit got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            step(0, '0, '0);
            got = req;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: no o_sample_req within 300 cycles got 0 expected 1", name);
        end
    endtask

    typedef struct {
        int off;
        logic [D-1:0] l, r, el, er;
        logic eu;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int first_req, first_und, cnt;
        logic und64;
        vecs[0] = '{10, 24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 1'b0};
        vecs[1] = '{5,  24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0};
        vecs[2] = '{-1, 24'h0,      24'h0,      24'h7FFFFF, 24'h7FFFFF, 1'b1};
        vecs[3] = '{-1, 24'h0,      24'h0,      24'h7FFFFF, 24'h7FFFFF, 1'b1};
        vecs[4] = '{-1, 24'h0,      24'h0,      24'h7FFFFF, 24'h7FFFFF, 1'b1};
        vecs[5] = '{20, 24'h800000, 24'h000010, 24'h800000, 24'h000010, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {bclk, lrck, o_l, o_r, req, und, sticky}, 64'h0);
        rst_n = 1'b1;

        first_req = -1; first_und = -1; und64 = 1'bx;
        for (int k = 1; k <= 330; k++) begin
            step(0, '0, '0);
            if (req && first_req < 0) first_req = k;
            if (und && first_und < 0) first_und = k;
            if (k == 64) und64 = und;
        end
        chk("first_req_cycle", 64'(first_req), 64'd64);
        chk("no_underrun_at_64", {63'd0, und64}, 64'd0);
        chk("first_underrun_cycle", 64'(first_und), 64'd320);

        wait_req("sync");
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].off; c++) step(0, '0, '0);
            if (vecs[i].off >= 0) step(1, vecs[i].l, vecs[i].r);
            wait_req("vec_req");
            chk("vec_l", 64'(o_l), 64'(vecs[i].el));
            chk("vec_r", 64'(o_r), 64'(vecs[i].er));
            chk("vec_underrun", 64'(und), 64'(vecs[i].eu));
        end
        chk("sticky_after_resume", 64'(sticky), 64'd1);

        repeat (3) step(0, '0, '0);
        step(1, 24'h000001, 24'h000001);
        repeat (3) step(0, '0, '0);
        step(1, 24'h000002, 24'h000002);
        wait_req("double_req");
        chk("double_valid_l", 64'(o_l), 64'h000001);
        chk("double_valid_r", 64'(o_r), 64'h000001);

        repeat (FRAME - 1) step(0, '0, '0);
        step(1, 24'h55AA33, 24'h0F0F0F);
        chk("bypass_req", 64'(req), 64'd1);
        chk("bypass_l", 64'(o_l), 64'h55AA33);
        chk("bypass_r", 64'(o_r), 64'h0F0F0F);
        chk("bypass_no_underrun", 64'(und), 64'd0);
        repeat (FRAME - 1) step(0, '0, '0);
        step(0, '0, '0);
        chk("bypass_stays_wait", 64'(und), 64'd1);
        chk("bypass_hold_l", 64'(o_l), 64'h55AA33);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 79) == 0) step(1, D'($urandom), D'($urandom));
            else step(0, '0, '0);
        end

        wait_req("pre_reset");
        repeat (100) step(0, '0, '0);
        chk("mid_right_half", 64'(lrck), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {bclk, lrck, o_l, o_r, req, und, sticky}, 64'h0);
        @(negedge clk);
        step(0, '0, '0);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 300 && cnt == 0; k++) begin
            step(0, '0, '0);
            if (req) cnt = k;
        end
        chk("req_after_rereset", 64'(cnt), 64'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_i2s_clkgen.md
# audio_i2s_clkgen

I2S timing master and sample hand-off stage directly upstream of the I2S serializer. Runs on the audio master clock and divides it into the bit clock and left/right word clock that the serializer consumes. Requests one stereo sample per frame from the synth engine and presents held, frame-stable left/right words to the serializer. Flags underruns when the engine misses its deadline.

## Interface
- AUD_BIT_DEPTH, 24, width of sample words.
- MCLK_PER_BCLK, 4, master-clock cycles per bit-clock period; even, ≥2.
- iAUD_XCK  in  1  audio master clock; all logic on its rising edge.
- reset_reg_N  in  1  reset, asynchronous, active-low.
- i_lsound  in  AUD_BIT_DEPTH  left sample from synth engine, signed.
- i_rsound  in  AUD_BIT_DEPTH  right sample from synth engine, signed.
- i_sample_valid  in  1  one-cycle strobe qualifying i_lsound/i_rsound.
- oAUD_BCLK  out  1  bit clock to codec and serializer.
- oAUD_DACLRCK  out  1  word clock; 0 = left half, 1 = right half.
- o_lsound_out  out  AUD_BIT_DEPTH  held left word to serializer.
- o_rsound_out  out  AUD_BIT_DEPTH  held right word to serializer.
- o_sample_req  out  1  one-cycle request for the next stereo sample.
- o_underrun  out  1  one-cycle pulse: deadline missed, previous sample repeated.
- o_underrun_sticky  out  1  set by any underrun, cleared only by reset.

## Operation
- div_cnt counts 0..MCLK_PER_BCLK-1 and wraps. tick = (div_cnt == MCLK_PER_BCLK-1).
- bclk_cnt is 6 bits and increments on tick, wrapping 63→0. Frame = 64 BCLKs, 32 per channel.
- oAUD_BCLK is a flop:
  - set on the edge where div_cnt goes MCLK_PER_BCLK/2-1 → MCLK_PER_BCLK/2.
  - cleared on the tick edge.
- oAUD_DACLRCK is a flop loaded with the post-increment bclk_cnt[5] on tick. It changes on the same edge as the BCLK falling edge.
- update point = the tick edge where bclk_cnt goes 15→16 (middle of the left half). This is far from the serializer's end-of-half latch.
- Staging regs capture i_lsound/i_rsound on i_sample_valid.
- FSM states:
  - WAIT_DATA:
    - valid → capture, go to HAVE_DATA.
    - update point without valid → o_underrun pulse, sticky set, outputs unchanged, o_sample_req pulse, stay in WAIT_DATA.
  - HAVE_DATA:
    - further valids are ignored; staging is not overwritten.
    - update point → load outputs from staging, o_sample_req pulse, go to WAIT_DATA.
- Valid in the update-point cycle while in WAIT_DATA:
  - inputs load straight to the outputs (bypass).
  - no underrun.
  - o_sample_req still pulses.
  - state stays WAIT_DATA.
- Valid in the update-point cycle while in HAVE_DATA: ignored.
- Outputs change only at update points.
- Sample values pass through unmodified; no width conversion.

## Timing
- Reset values:
  - all counters 0.
  - oAUD_BCLK 0, oAUD_DACLRCK 0.
  - o_lsound_out and o_rsound_out 0, staging 0.
  - o_sample_req 0, o_underrun 0, sticky 0.
  - state HAVE_DATA, so the first update loads zeros without flagging an underrun.
- First o_sample_req at the first update point, rising edge 16·MCLK_PER_BCLK after reset release. Subsequent requests every 64·MCLK_PER_BCLK cycles.
- Engine deadline is one full frame: a valid strictly after a request and on or before the next update point is on time.
- Sample latency: a valid captured in frame n appears on the outputs at update point n+1 (bypass case: the same edge).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-frame: everything returns to reset values immediately (async). Any pending sample is lost.

## Structure
- Shared audio package holds:
  - BCLK_PER_FRAME = 64, BCLK_PER_CH = 32.
  - UPDATE_BCLK = 16.
  - FSM state enum {WAIT_DATA, HAVE_DATA}.
  - These are shared with the serializer, which relies on the 32-slot half frame.
- One sub-module: audio_bclk_divider (div_cnt, bclk_cnt, registered BCLK/LRCK, tick/update strobes).
- Handshake FSM and staging stay in the top.

## Test plan
- Reset release, MCLK_PER_BCLK=4, no valids:
  - BCLK period 4 cycles, 50% duty.
  - LRCK toggles every 128 cycles.
  - first o_sample_req at cycle 64, no underrun at cycle 64, o_underrun at cycle 320.
- Valid (L=0x123456, R=0xABCDEF) 10 cycles after a request → both outputs show those values from the next update point. No underrun.
- Two valids in one frame (0x000001, then 0x000002) → outputs take 0x000001. Second valid ignored.
- Engine silent for 3 frames after sample 0x7FFFFF:
  - outputs hold 0x7FFFFF.
  - three o_underrun pulses.
  - sticky stays 1 after normal data resumes.
- Valid coincident with the update point in WAIT_DATA → outputs load on the same edge. No underrun. State stays WAIT_DATA.
- Assert reset_reg_N low mid-right-half:
  - all outputs go to 0 asynchronously.
  - after release, the first request again arrives 16·MCLK_PER_BCLK cycles later.
